// File: rtl/mmu_xlate_arbiter_if.sv
// Bus bundle between the AXI MMU wrapper front end, the translation arbiter
// and the shared translation engine.
//   rd_* / wr_* : per-requester translation request and one-cycle result
//   xl_*        : engine job (start/abort out, result/done/fault in)
//   timeout_evt, busy, last_grant : arbiter status
// Modports: slave = arbiter view, master = front end / engine view.
interface mmu_xlate_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned SIZE_W = 3
);
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_vaddr;
    logic [LEN_W-1:0]  rd_len;
    logic [SIZE_W-1:0] rd_size;
    logic              rd_resp_valid;
    logic [ADDR_W-1:0] rd_paddr;
    logic              rd_resp_err;

    logic              wr_req_valid;
    logic              wr_req_ready;
    logic [ADDR_W-1:0] wr_vaddr;
    logic [LEN_W-1:0]  wr_len;
    logic [SIZE_W-1:0] wr_size;
    logic              wr_resp_valid;
    logic [ADDR_W-1:0] wr_paddr;
    logic              wr_resp_err;

    logic              xl_start;
    logic              xl_is_write;
    logic [ADDR_W-1:0] xl_vaddr;
    logic [LEN_W-1:0]  xl_len;
    logic [SIZE_W-1:0] xl_size;
    logic [ADDR_W-1:0] xl_paddr;
    logic              xl_done;
    logic              xl_fault;
    logic              xl_abort;

    logic              timeout_evt;
    logic              busy;
    logic              last_grant;

    modport slave (
        input  rd_req_valid, rd_vaddr, rd_len, rd_size,
        output rd_req_ready, rd_resp_valid, rd_paddr, rd_resp_err,
        input  wr_req_valid, wr_vaddr, wr_len, wr_size,
        output wr_req_ready, wr_resp_valid, wr_paddr, wr_resp_err,
        output xl_start, xl_is_write, xl_vaddr, xl_len, xl_size, xl_abort,
        input  xl_paddr, xl_done, xl_fault,
        output timeout_evt, busy, last_grant
    );

    modport master (
        output rd_req_valid, rd_vaddr, rd_len, rd_size,
        input  rd_req_ready, rd_resp_valid, rd_paddr, rd_resp_err,
        output wr_req_valid, wr_vaddr, wr_len, wr_size,
        input  wr_req_ready, wr_resp_valid, wr_paddr, wr_resp_err,
        input  xl_start, xl_is_write, xl_vaddr, xl_len, xl_size, xl_abort,
        output xl_paddr, xl_done, xl_fault,
        input  timeout_evt, busy, last_grant
    );
endinterface

// File: rtl/mmu_xlate_arbiter.sv
// Shares one address-translation engine between the AR (read) and AW (write)
// translation requesters. One job at a time, round-robin on ties, engine
// sequenced IDLE -> ISSUE -> WAIT -> RESP, result returned as a one-cycle
// pulse on the granted side.
// Ports:
//   clk   : engine clock
//   reset : synchronous, active-high
//   bus   : mmu_xlate_arbiter_if.slave (requests, results, engine job, status)
// rd/wr_req_ready are combinational grants; xl_abort/timeout_evt are
// combinational pulses; every other output is a register.
// Optional feature: define MMU_XLATE_TIMEOUT_EN to abort an engine job that
// has not completed within TIMEOUT_CYCLES WAIT cycles.
module mmu_xlate_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned LEN_W          = 8,
    parameter int unsigned SIZE_W         = 3,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic              clk,
    input logic              reset,
    mmu_xlate_arbiter_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    // Elaboration guard on the timeout limit.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              xl_start_q, xl_start_d;
    logic              xl_is_write_q, xl_is_write_d;
    logic [ADDR_W-1:0] xl_vaddr_q, xl_vaddr_d;
    logic [LEN_W-1:0]  xl_len_q, xl_len_d;
    logic [SIZE_W-1:0] xl_size_q, xl_size_d;
    logic              rd_resp_valid_q, rd_resp_valid_d;
    logic [ADDR_W-1:0] rd_paddr_q, rd_paddr_d;
    logic              rd_resp_err_q, rd_resp_err_d;
    logic              wr_resp_valid_q, wr_resp_valid_d;
    logic [ADDR_W-1:0] wr_paddr_q, wr_paddr_d;
    logic              wr_resp_err_q, wr_resp_err_d;
    logic              busy_q, busy_d;

    logic              rd_grant_c, wr_grant_c;
    logic              fin_c;
    logic [ADDR_W-1:0] fin_paddr_c;
    logic              fin_err_c;

`ifdef MMU_XLATE_TIMEOUT_EN
    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_c;
`endif

    // Next-state, grant and output-register computation.
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        xl_start_d      = 1'b0;
        xl_is_write_d   = xl_is_write_q;
        xl_vaddr_d      = xl_vaddr_q;
        xl_len_d        = xl_len_q;
        xl_size_d       = xl_size_q;
        rd_resp_valid_d = 1'b0;
        rd_paddr_d      = rd_paddr_q;
        rd_resp_err_d   = rd_resp_err_q;
        wr_resp_valid_d = 1'b0;
        wr_paddr_d      = wr_paddr_q;
        wr_resp_err_d   = wr_resp_err_q;
        rd_grant_c      = 1'b0;
        wr_grant_c      = 1'b0;
        fin_c           = 1'b0;
        fin_paddr_c     = '0;
        fin_err_c       = 1'b0;
`ifdef MMU_XLATE_TIMEOUT_EN
        cnt_d           = cnt_q;
        abort_c         = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                // Tie goes to the side opposite the previous grant.
                if (!reset) begin
                    rd_grant_c = bus.rd_req_valid && (!bus.wr_req_valid || last_grant_q);
                    wr_grant_c = bus.wr_req_valid && (!bus.rd_req_valid || !last_grant_q);
                end
                if (rd_grant_c) begin
                    xl_vaddr_d    = bus.rd_vaddr;
                    xl_len_d      = bus.rd_len;
                    xl_size_d     = bus.rd_size;
                    xl_is_write_d = 1'b0;
                    last_grant_d  = 1'b0;
                    xl_start_d    = 1'b1;
                    state_d       = S_ISSUE;
                end else if (wr_grant_c) begin
                    xl_vaddr_d    = bus.wr_vaddr;
                    xl_len_d      = bus.wr_len;
                    xl_size_d     = bus.wr_size;
                    xl_is_write_d = 1'b1;
                    last_grant_d  = 1'b1;
                    xl_start_d    = 1'b1;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef MMU_XLATE_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                // A done in the timeout cycle takes priority over the abort.
                if (bus.xl_done) begin
                    fin_c       = 1'b1;
                    fin_paddr_c = bus.xl_fault ? '0 : bus.xl_paddr;
                    fin_err_c   = bus.xl_fault;
                end
`ifdef MMU_XLATE_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    abort_c     = 1'b1;
                    fin_c       = 1'b1;
                    fin_paddr_c = '0;
                    fin_err_c   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Result lands on the granted side in the RESP cycle and then holds.
        if (fin_c) begin
            state_d = S_RESP;
            if (xl_is_write_q) begin
                wr_resp_valid_d = 1'b1;
                wr_paddr_d      = fin_paddr_c;
                wr_resp_err_d   = fin_err_c;
            end else begin
                rd_resp_valid_d = 1'b1;
                rd_paddr_d      = fin_paddr_c;
                rd_resp_err_d   = fin_err_c;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            last_grant_q    <= 1'b1;
            xl_start_q      <= 1'b0;
            xl_is_write_q   <= 1'b0;
            xl_vaddr_q      <= '0;
            xl_len_q        <= '0;
            xl_size_q       <= '0;
            rd_resp_valid_q <= 1'b0;
            rd_paddr_q      <= '0;
            rd_resp_err_q   <= 1'b0;
            wr_resp_valid_q <= 1'b0;
            wr_paddr_q      <= '0;
            wr_resp_err_q   <= 1'b0;
            busy_q          <= 1'b0;
`ifdef MMU_XLATE_TIMEOUT_EN
            cnt_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            xl_start_q      <= xl_start_d;
            xl_is_write_q   <= xl_is_write_d;
            xl_vaddr_q      <= xl_vaddr_d;
            xl_len_q        <= xl_len_d;
            xl_size_q       <= xl_size_d;
            rd_resp_valid_q <= rd_resp_valid_d;
            rd_paddr_q      <= rd_paddr_d;
            rd_resp_err_q   <= rd_resp_err_d;
            wr_resp_valid_q <= wr_resp_valid_d;
            wr_paddr_q      <= wr_paddr_d;
            wr_resp_err_q   <= wr_resp_err_d;
            busy_q          <= busy_d;
`ifdef MMU_XLATE_TIMEOUT_EN
            cnt_q           <= cnt_d;
`endif
        end
    end

    assign bus.rd_req_ready  = rd_grant_c;
    assign bus.wr_req_ready  = wr_grant_c;
    assign bus.rd_resp_valid = rd_resp_valid_q;
    assign bus.rd_paddr      = rd_paddr_q;
    assign bus.rd_resp_err   = rd_resp_err_q;
    assign bus.wr_resp_valid = wr_resp_valid_q;
    assign bus.wr_paddr      = wr_paddr_q;
    assign bus.wr_resp_err   = wr_resp_err_q;
    assign bus.xl_start      = xl_start_q;
    assign bus.xl_is_write   = xl_is_write_q;
    assign bus.xl_vaddr      = xl_vaddr_q;
    assign bus.xl_len        = xl_len_q;
    assign bus.xl_size       = xl_size_q;
    assign bus.busy          = busy_q;
    assign bus.last_grant    = last_grant_q;
`ifdef MMU_XLATE_TIMEOUT_EN
    assign bus.xl_abort      = abort_c;
    assign bus.timeout_evt   = abort_c;
`else
    assign bus.xl_abort      = 1'b0;
    assign bus.timeout_evt   = 1'b0;
`endif

endmodule

// File: tb/tb_mmu_xlate_arbiter.sv
// Directed self-checking bench for mmu_xlate_arbiter. Inputs are driven 1 ns
// after the rising edge; registered outputs are sampled there, combinational
// grants/aborts 1 ns later.
module tb_mmu_xlate_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned SIZE_W = 3;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    mmu_xlate_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .SIZE_W(SIZE_W)) bus ();

    mmu_xlate_arbiter #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .SIZE_W(SIZE_W), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.last_grant !== 1'b1) $display("FAIL reset_last_grant: got %b want 1", bus.last_grant); else n_pass++;
        n_checks++; if ({bus.xl_start, bus.xl_is_write, bus.rd_resp_valid, bus.wr_resp_valid} !== 4'b0000)
            $display("FAIL reset_pulses: got %b want 0000", {bus.xl_start, bus.xl_is_write, bus.rd_resp_valid, bus.wr_resp_valid}); else n_pass++;
        n_checks++; if ({bus.xl_vaddr, bus.rd_paddr, bus.wr_paddr} !== 96'h0)
            $display("FAIL reset_addrs: got %h want 0", {bus.xl_vaddr, bus.rd_paddr, bus.wr_paddr}); else n_pass++;
        n_checks++; if ({bus.rd_req_ready, bus.wr_req_ready, bus.xl_abort, bus.timeout_evt} !== 4'b0000)
            $display("FAIL reset_comb: got %b want 0000", {bus.rd_req_ready, bus.wr_req_ready, bus.xl_abort, bus.timeout_evt}); else n_pass++;
    endtask

    task automatic test_single_read();
        tick();
        bus.rd_req_valid = 1'b1; bus.rd_vaddr = 32'h0000_1000; bus.rd_len = 8'd4; bus.rd_size = 3'd1;
        #1;
        n_checks++; if ({bus.rd_req_ready, bus.wr_req_ready} !== 2'b10) $display("FAIL single_ready: got %b want 10", {bus.rd_req_ready, bus.wr_req_ready}); else n_pass++;
        tick(); // T+1
        bus.rd_req_valid = 1'b0;
        n_checks++; if (bus.xl_start !== 1'b1) $display("FAIL single_start: got %b want 1", bus.xl_start); else n_pass++;
        n_checks++; if ({bus.xl_vaddr, bus.xl_len, bus.xl_size, bus.xl_is_write} !== {32'h0000_1000, 8'd4, 3'd1, 1'b0})
            $display("FAIL single_job: got %h %h %h %b want 00001000 04 1 0", bus.xl_vaddr, bus.xl_len, bus.xl_size, bus.xl_is_write); else n_pass++;
        n_checks++; if ({bus.busy, bus.last_grant} !== 2'b10) $display("FAIL single_busy_lg: got %b want 10", {bus.busy, bus.last_grant}); else n_pass++;
        tick(); // T+2
        n_checks++; if (bus.xl_start !== 1'b0) $display("FAIL single_start_once: got %b want 0", bus.xl_start); else n_pass++;
        tick(); // T+3
        tick(); // T+4
        bus.xl_done = 1'b1; bus.xl_paddr = 32'h8000_1000; bus.xl_fault = 1'b0;
        n_checks++; if ({bus.rd_resp_valid, bus.xl_vaddr} !== {1'b0, 32'h0000_1000})
            $display("FAIL single_hold: got %b %h want 0 00001000", bus.rd_resp_valid, bus.xl_vaddr); else n_pass++;
        tick(); // T+5
        bus.xl_done = 1'b0;
        n_checks++; if ({bus.rd_resp_valid, bus.rd_paddr, bus.rd_resp_err, bus.wr_resp_valid} !== {1'b1, 32'h8000_1000, 1'b0, 1'b0})
            $display("FAIL single_resp: got %b %h %b %b want 1 80001000 0 0", bus.rd_resp_valid, bus.rd_paddr, bus.rd_resp_err, bus.wr_resp_valid); else n_pass++;
        tick(); // T+6
        n_checks++; if ({bus.rd_resp_valid, bus.rd_paddr, bus.busy} !== {1'b0, 32'h8000_1000, 1'b0})
            $display("FAIL single_after: got %b %h %b want 0 80001000 0", bus.rd_resp_valid, bus.rd_paddr, bus.busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic              exp_w;
        logic [ADDR_W-1:0] exp_p;
        apply_reset();
        bus.rd_req_valid = 1'b1; bus.rd_vaddr = 32'h0000_2000; bus.rd_len = 8'd1; bus.rd_size = 3'd2;
        bus.wr_req_valid = 1'b1; bus.wr_vaddr = 32'h0000_3000; bus.wr_len = 8'd2; bus.wr_size = 3'd3;
        for (int i = 0; i < 6; i++) begin
            exp_w = (i % 2) == 1;
            exp_p = exp_w ? 32'hA000_3000 : 32'hB000_2000;
            #1;
            n_checks++; if ({bus.rd_req_ready, bus.wr_req_ready} !== {~exp_w, exp_w})
                $display("FAIL tie_grant%0d: got %b want %b", i, {bus.rd_req_ready, bus.wr_req_ready}, {~exp_w, exp_w}); else n_pass++;
            tick(); // ISSUE
            n_checks++; if ({bus.last_grant, bus.xl_is_write, bus.rd_req_ready, bus.wr_req_ready} !== {exp_w, exp_w, 2'b00})
                $display("FAIL tie_issue%0d: got %b want %b", i, {bus.last_grant, bus.xl_is_write, bus.rd_req_ready, bus.wr_req_ready}, {exp_w, exp_w, 2'b00}); else n_pass++;
            tick(); // WAIT
            bus.xl_done = 1'b1; bus.xl_paddr = exp_p; bus.xl_fault = 1'b0;
            tick(); // RESP
            bus.xl_done = 1'b0;
            if (i == 5) begin
                bus.rd_req_valid = 1'b0;
                bus.wr_req_valid = 1'b0;
            end
            n_checks++; if ({bus.rd_resp_valid, bus.wr_resp_valid} !== {~exp_w, exp_w})
                $display("FAIL tie_resp%0d: got %b want %b", i, {bus.rd_resp_valid, bus.wr_resp_valid}, {~exp_w, exp_w}); else n_pass++;
            n_checks++; if ((exp_w ? bus.wr_paddr : bus.rd_paddr) !== exp_p)
                $display("FAIL tie_paddr%0d: got %h want %h", i, exp_w ? bus.wr_paddr : bus.rd_paddr, exp_p); else n_pass++;
            tick(); // IDLE, next acceptance
        end
    endtask

    task automatic test_fault();
        bus.wr_req_valid = 1'b1; bus.wr_vaddr = 32'h10FF_0000; bus.wr_len = 8'd0; bus.wr_size = 3'd2;
        tick(); // ISSUE
        bus.wr_req_valid = 1'b0;
        tick(); // WAIT
        bus.xl_done = 1'b1; bus.xl_fault = 1'b1; bus.xl_paddr = 32'hFFFF_FFFF;
        tick(); // RESP
        bus.xl_done = 1'b0; bus.xl_fault = 1'b0;
        n_checks++; if ({bus.wr_resp_valid, bus.wr_paddr, bus.wr_resp_err, bus.rd_resp_valid} !== {1'b1, 32'h0, 1'b1, 1'b0})
            $display("FAIL fault_resp: got %b %h %b %b want 1 00000000 1 0", bus.wr_resp_valid, bus.wr_paddr, bus.wr_resp_err, bus.rd_resp_valid); else n_pass++;
        tick();
        n_checks++; if ({bus.wr_resp_valid, bus.wr_resp_err} !== 2'b01) $display("FAIL fault_hold: got %b want 01", {bus.wr_resp_valid, bus.wr_resp_err}); else n_pass++;
    endtask

    task automatic test_stray_done();
        bus.xl_done = 1'b1; bus.xl_paddr = 32'hDEAD_BEEF;
        tick();
        bus.xl_done = 1'b0;
        n_checks++; if ({bus.busy, bus.rd_resp_valid, bus.wr_resp_valid} !== 3'b000)
            $display("FAIL stray_idle: got %b want 000", {bus.busy, bus.rd_resp_valid, bus.wr_resp_valid}); else n_pass++;
        bus.rd_req_valid = 1'b1; bus.rd_vaddr = 32'h0000_4000; bus.rd_len = 8'd7; bus.rd_size = 3'd0;
        tick(); // ISSUE
        bus.rd_req_valid = 1'b0;
        bus.xl_done = 1'b1; bus.xl_paddr = 32'hDEAD_BEEF;
        tick(); // WAIT
        bus.xl_done = 1'b0;
        n_checks++; if ({bus.busy, bus.rd_resp_valid} !== 2'b10) $display("FAIL stray_issue: got %b want 10", {bus.busy, bus.rd_resp_valid}); else n_pass++;
        tick(); // WAIT
        bus.xl_done = 1'b1; bus.xl_paddr = 32'h9000_4000;
        n_checks++; if (bus.rd_resp_valid !== 1'b0) $display("FAIL stray_wait: got %b want 0", bus.rd_resp_valid); else n_pass++;
        tick(); // RESP
        bus.xl_done = 1'b0;
        n_checks++; if ({bus.rd_resp_valid, bus.rd_paddr, bus.rd_resp_err} !== {1'b1, 32'h9000_4000, 1'b0})
            $display("FAIL stray_resp: got %b %h %b want 1 90004000 0", bus.rd_resp_valid, bus.rd_paddr, bus.rd_resp_err); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        bus.rd_req_valid = 1'b1; bus.rd_vaddr = 32'h0000_5000; bus.rd_len = 8'd3; bus.rd_size = 3'd1;
        tick(); // ISSUE
        bus.rd_req_valid = 1'b0;
        tick(); // WAIT 1
        tick(); // WAIT 2
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if ({bus.busy, bus.last_grant, bus.rd_resp_valid, bus.xl_start} !== 4'b0100)
            $display("FAIL rstwait_state: got %b want 0100", {bus.busy, bus.last_grant, bus.rd_resp_valid, bus.xl_start}); else n_pass++;
        n_checks++; if ({bus.xl_vaddr, bus.rd_paddr, bus.wr_resp_err} !== 65'h0)
            $display("FAIL rstwait_regs: got %h %h %b want 0", bus.xl_vaddr, bus.rd_paddr, bus.wr_resp_err); else n_pass++;
        bus.xl_done = 1'b1; bus.xl_paddr = 32'h1234_5678;
        tick();
        bus.xl_done = 1'b0;
        tick();
        n_checks++; if ({bus.busy, bus.rd_resp_valid, bus.wr_resp_valid, bus.rd_paddr} !== 35'h0)
            $display("FAIL rstwait_late_done: got %b %b %b %h want 0", bus.busy, bus.rd_resp_valid, bus.wr_resp_valid, bus.rd_paddr); else n_pass++;
    endtask

`ifdef MMU_XLATE_TIMEOUT_EN
    task automatic test_timeout();
        for (int run = 0; run < 2; run++) begin
            bus.rd_req_valid = 1'b1; bus.rd_vaddr = 32'h0000_6000; bus.rd_len = 8'd1; bus.rd_size = 3'd1;
            tick(); // ISSUE
            bus.rd_req_valid = 1'b0;
            for (int w = 1; w <= 16; w++) begin
                tick(); // WAIT cycle w
                if (w == 16 && run == 1) begin
                    bus.xl_done = 1'b1; bus.xl_paddr = 32'h7000_6000;
                end
                #1;
                if (w == 15 || w == 16) begin
                    n_checks++; if ({bus.xl_abort, bus.timeout_evt} !== {2{(w == 16) && (run == 0)}})
                        $display("FAIL to_abort_r%0d_w%0d: got %b want %b", run, w, {bus.xl_abort, bus.timeout_evt}, {2{(w == 16) && (run == 0)}}); else n_pass++;
                end
                #(-1 + 1);
            end
            tick(); // RESP
            bus.xl_done = 1'b0;
            n_checks++; if ({bus.rd_resp_valid, bus.rd_paddr, bus.rd_resp_err} !== ((run == 0) ? {1'b1, 32'h0, 1'b1} : {1'b1, 32'h7000_6000, 1'b0}))
                $display("FAIL to_resp_r%0d: got %b %h %b", run, bus.rd_resp_valid, bus.rd_paddr, bus.rd_resp_err); else n_pass++;
            tick();
        end
    endtask
`else
    task automatic test_timeout();
        logic seen_abort;
        seen_abort = 1'b0;
        bus.rd_req_valid = 1'b1; bus.rd_vaddr = 32'h0000_6000; bus.rd_len = 8'd1; bus.rd_size = 3'd1;
        tick(); // ISSUE
        bus.rd_req_valid = 1'b0;
        for (int w = 1; w <= 20; w++) begin
            tick();
            #1;
            seen_abort = seen_abort | bus.xl_abort | bus.timeout_evt;
        end
        n_checks++; if (seen_abort !== 1'b0) $display("FAIL notimeout_abort: got %b want 0", seen_abort); else n_pass++;
        n_checks++; if ({bus.busy, bus.rd_resp_valid} !== 2'b10) $display("FAIL notimeout_wait: got %b want 10", {bus.busy, bus.rd_resp_valid}); else n_pass++;
        bus.xl_done = 1'b1; bus.xl_paddr = 32'h7000_6000;
        tick(); // RESP
        bus.xl_done = 1'b0;
        n_checks++; if ({bus.rd_resp_valid, bus.rd_paddr, bus.rd_resp_err} !== {1'b1, 32'h7000_6000, 1'b0})
            $display("FAIL notimeout_resp: got %b %h %b want 1 70006000 0", bus.rd_resp_valid, bus.rd_paddr, bus.rd_resp_err); else n_pass++;
        tick();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        bus.rd_req_valid = 1'b0; bus.rd_vaddr = '0; bus.rd_len = '0; bus.rd_size = '0;
        bus.wr_req_valid = 1'b0; bus.wr_vaddr = '0; bus.wr_len = '0; bus.wr_size = '0;
        bus.xl_paddr = '0; bus.xl_done = 1'b0; bus.xl_fault = 1'b0;

        test_reset();
        test_single_read();
        test_back_to_back();
        test_fault();
        test_stray_done();
        test_reset_mid_wait();
        test_timeout();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
